// File: rtl/round_robin_dispatch.sv
// Round-robin dispatcher: each accepted word goes to lanes 0..n_outputs-1 in strict rotation.
// Define ROUND_ROBIN_DISPATCH_CREDIT_EN to build per-lane credit counters and the sticky credit_err flag.
module round_robin_dispatch #(
    parameter int width           = 16,
    parameter int n_outputs       = 4,
    parameter int max_outstanding = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         up_vld,
    output logic                         up_rdy,
    input  logic [width-1:0]             up_data,
    output logic [n_outputs-1:0]         down_vlds,
    output logic [width-1:0]             down_data,
    input  logic [n_outputs-1:0]         done_vlds,
    output logic [$clog2(n_outputs)-1:0] lane_ptr,
    output logic                         credit_err
);
    localparam int               PTR_W     = $clog2(n_outputs);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(n_outputs - 1);

    function automatic logic [n_outputs-1:0] lane_onehot(input logic [PTR_W-1:0] lane);
        logic [n_outputs-1:0] oh;
        for (int i = 0; i < n_outputs; i++) begin
            if (PTR_W'(i) == lane) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    logic                 accept_s;
    logic [n_outputs-1:0] down_vlds_d, down_vlds_q;
    logic [width-1:0]     down_data_d, down_data_q;
    logic [PTR_W-1:0]     lane_ptr_d, lane_ptr_q;

    assign accept_s = up_vld && up_rdy;

    // Issue strobe, data capture and rotation pointer; the wrap is an explicit compare.
    always_comb begin
        down_vlds_d = '0;
        down_data_d = down_data_q;
        lane_ptr_d  = lane_ptr_q;
        if (accept_s) begin
            down_vlds_d = lane_onehot(lane_ptr_q);
            down_data_d = up_data;
            if (lane_ptr_q == LAST_LANE) begin
                lane_ptr_d = '0;
            end else begin
                lane_ptr_d = lane_ptr_q + PTR_W'(1);
            end
        end else begin
            down_vlds_d = '0;
        end
    end

    // Datapath and rotation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_vlds_q <= '0;
            down_data_q <= '0;
            lane_ptr_q  <= '0;
        end else begin
            down_vlds_q <= down_vlds_d;
            down_data_q <= down_data_d;
            lane_ptr_q  <= lane_ptr_d;
        end
    end

    assign down_vlds = down_vlds_q;
    assign down_data = down_data_q;
    assign lane_ptr  = lane_ptr_q;

`ifdef ROUND_ROBIN_DISPATCH_CREDIT_EN
    localparam int                CRED_W   = $clog2(max_outstanding + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(max_outstanding);

    logic [CRED_W-1:0] credit_d [n_outputs];
    logic [CRED_W-1:0] credit_q [n_outputs];
    logic              credit_err_d, credit_err_q;

    // Rotation never skips: readiness depends only on the lane currently pointed at.
    assign up_rdy = (credit_q[lane_ptr_q] != '0);

    // Per-lane credit bookkeeping; an issue and a completion in the same cycle cancel out.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int i = 0; i < n_outputs; i++) begin
            credit_d[i] = credit_q[i];
            if (done_vlds[i] && !down_vlds_d[i]) begin
                if (credit_q[i] == CRED_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CRED_W'(1);
                end
            end else if (down_vlds_d[i] && !done_vlds[i]) begin
                credit_d[i] = credit_q[i] - CRED_W'(1);
            end else begin
                credit_d[i] = credit_q[i];
            end
        end
    end

    // Credit counters and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < n_outputs; i++) begin
                credit_q[i] <= CRED_MAX;
            end
            credit_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < n_outputs; i++) begin
                credit_q[i] <= credit_d[i];
            end
            credit_err_q <= credit_err_d;
        end
    end

    assign credit_err = credit_err_q;
`else
    logic unused_done_s;

    assign unused_done_s = ^done_vlds;
    assign up_rdy        = 1'b1;
    assign credit_err    = 1'b0;
`endif

endmodule

// File: doc/round_robin_dispatch.md
# round_robin_dispatch

Upstream companion of the in-order collector. Takes one valid/ready stream and issues each accepted word to exactly one of `n_outputs` variable-latency processing lanes in strict rotation (lane 0, 1, …, n_outputs-1, 0, …). The downstream collector reconstructs order from this rotation alone. Per-lane credit counters bound the number of words in flight in each lane, so no lane is ever overrun.

## Interface
Parameters:
- `width`, 16: data word width.
- `n_outputs`, 4: number of lanes, ≥2, need not be a power of two.
- `max_outstanding`, 2: credits per lane, ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `up_vld`  in  1  upstream word valid.
- `up_rdy`  out  1  dispatcher can accept this cycle.
- `up_data`  in  width  upstream word.
- `down_vlds`  out  n_outputs  one-hot issue strobe, one bit per lane.
- `down_data`  out  width  issued word, shared by all lanes; meaningful only while any `down_vlds` bit is set.
- `done_vlds`  in  n_outputs  per-lane completion pulse; each pulse returns one credit.
- `lane_ptr`  out  $clog2(n_outputs)  lane that receives the next accepted word.
- `credit_err`  out  1  sticky protocol-error flag.

## Operation
- Accept condition: `up_vld && up_rdy`.
- `up_rdy` is combinational: `credit[lane_ptr] != 0`. It does not depend on `up_vld`.
- On accept:
  - `down_data` is loaded with `up_data`.
  - `down_vlds` is loaded with a one-hot of `lane_ptr`.
  - `lane_ptr` advances by one, wrapping from n_outputs-1 to 0. The wrap uses a compare, not width overflow.
  - `credit[lane_ptr]` decrements.
- No accept: `down_vlds` goes to 0 next cycle. `down_data` holds its last value.
- Lanes have no backpressure. Each `down_vlds` bit is a single-cycle strobe.
- Credit update per lane i, applied every cycle, with `issue_i` = accept to lane i:
  - `done_vlds[i] && !issue_i`: +1.
  - `issue_i && !done_vlds[i]`: −1.
  - Both together: unchanged.
- Credit counter width is $clog2(max_outstanding+1).
- Credit overflow: a `done_vlds[i]` arriving while credit[i]==max_outstanding and no issue to lane i that cycle.
  - The counter saturates.
  - `credit_err` sets and stays set until reset.
- Multiple `done_vlds` bits may be set in one cycle. Each is handled independently.
- Rotation never skips a lane. If the next lane has no credit, the dispatcher stalls, even when other lanes have credit.

## Timing
- Reset values:
  - `down_vlds`=0.
  - `down_data`=0.
  - `lane_ptr`=0.
  - every credit = max_outstanding.
  - `credit_err`=0.
  - `up_rdy`=1.
- Latency: a word accepted at edge N is visible on `down_vlds`/`down_data` after edge N, for exactly one cycle.
- Throughput: one word per cycle while credits allow.
- A `done_vlds[i]` sampled at edge N can enable an accept to lane i at edge N+1. There is no same-cycle credit bypass.
- Reset asserted mid-stream:
  - All state returns to reset values asynchronously.
  - An in-flight issue strobe is dropped.
  - Rotation restarts at lane 0.
- `up_data` is a don't-care when `up_vld`=0. X on `up_data` must not reach `down_vlds`.

## Configuration
- `ROUND_ROBIN_DISPATCH_CREDIT_EN` defined:
  - Credit counters and `credit_err` are built as described above.
- Not defined:
  - No credit state is built.
  - `up_rdy` is tied to 1.
  - `done_vlds` is ignored.
  - `credit_err` is tied to 0.
  - Rotation, latency and reset behaviour are unchanged.

## Test plan
All scenarios use width=16, n_outputs=4, max_outstanding=2, with the macro defined unless stated.
- Continuous stream 0..11, `done_vlds` echoed 2 cycles after each issue:
  - Words 0..11 issued one per cycle to lanes 0,1,2,3,0,…
  - `up_rdy` never drops.
  - `credit_err`=0.
- No `done_vlds`, continuous valid:
  - Exactly 8 words accepted.
  - `up_rdy`=0 from cycle 9 with `lane_ptr`=0.
  - Pulsing `done_vlds[0]` once allows exactly one more accept, to lane 0.
- Lane 2 starved of credits, lanes 0/1/3 returning credits:
  - Dispatcher stalls at `lane_ptr`=2.
  - No word is issued to lane 3 until lane 2 receives a credit.
- Same cycle `done_vlds[1]` and an accept to lane 1:
  - credit[1] unchanged.
  - `credit_err` stays 0.
- `done_vlds[3]` pulse right after reset:
  - `credit_err`=1 next cycle and stays 1.
  - `rst` pulse clears it to 0, with `lane_ptr`=0.
- Macro undefined, no `done_vlds`:
  - 20 consecutive words accepted with rotation 0..3 repeating.
  - `up_rdy`=1 throughout.
